// File: rtl/uart_hist_if.sv
// uart_hist_if: bundles the MIO_BUS-side strobes and the history status/display
// outputs of uart_history_buffer.
//   master : drives wr_en, clr, overwrite, wr_data, rd_en; observes the rest
//   slave  : the history buffer itself
// The irq signal exists only when UART_HIST_IRQ_EN is defined.
interface uart_hist_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                    wr_en;
    logic                    clr;
    logic                    overwrite;
    logic [DATA_W-1:0]       wr_data;
    logic                    rd_en;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic [CW-1:0]           count;
    logic                    empty;
    logic                    full;
    logic                    overflow;
    logic [DATA_W*DEPTH-1:0] display_data;
`ifdef UART_HIST_IRQ_EN
    logic                    irq;
`endif

    modport master (
        output wr_en, clr, overwrite, wr_data, rd_en,
        input  rd_data, rd_valid, count, empty, full, overflow, display_data
`ifdef UART_HIST_IRQ_EN
        , input irq
`endif
    );

    modport slave (
        input  wr_en, clr, overwrite, wr_data, rd_en,
        output rd_data, rd_valid, count, empty, full, overflow, display_data
`ifdef UART_HIST_IRQ_EN
        , output irq
`endif
    );
endinterface

// File: rtl/uart_history_buffer.sv
// uart_history_buffer: circular history of DEPTH characters between MIO_BUS and
// the display path, with a CPU pop port, selectable overflow policy (overwrite
// oldest / drop newest), status flags and an oldest-first flat display vector.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : uart_hist_if.slave (write/clear/read strobes, status, display)
// Optional feature macro: UART_HIST_IRQ_EN adds a registered irq output that is
// high when the fill level reaches IRQ_LEVEL or overflow is set.
module uart_history_buffer #(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 8,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(8'h20)
`ifdef UART_HIST_IRQ_EN
    , parameter int              IRQ_LEVEL = DEPTH - 1
`endif
) (
    input logic        clk,
    input logic        rst_n,
    uart_hist_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;

    logic is_full, is_empty, rd_ok;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign rd_ok    = bus.rd_en && !is_empty;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;

        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = FILL;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.wr_en) begin
            if (rd_ok) begin
                // Simultaneous pop and push: when full the pop frees the slot the
                // push lands in, so this is not an overflow.
                rd_data_d        = mem_q[rd_ptr_q];
                rd_valid_d       = 1'b1;
                rd_ptr_d         = rd_ptr_q + PW'(1);
                mem_d[wr_ptr_q]  = bus.wr_data;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end else if (!is_full) begin
                mem_d[wr_ptr_q]  = bus.wr_data;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                count_d          = count_q + CW'(1);
            end else if (bus.overwrite) begin
                mem_d[wr_ptr_q]  = bus.wr_data;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                rd_ptr_d         = rd_ptr_q + PW'(1);
                overflow_d       = 1'b1;
            end else begin
                overflow_d       = 1'b1;
            end
        end else if (rd_ok) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
            count_d    = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= FILL;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_HIST_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = ((count_d >= CW'(IRQ_LEVEL)) || overflow_d) && !bus.clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign bus.irq = irq_q;
`endif

    // Slot 0 (MSBs) is the oldest entry; slots beyond the fill level show FILL.
    logic [DATA_W*DEPTH-1:0] disp;
    logic [PW-1:0]           idx;

    always_comb begin
        disp = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            disp[DATA_W*(DEPTH-1-i) +: DATA_W] = (CW'(i) < count_q) ? mem_q[idx] : FILL;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.overflow     = overflow_q;
    assign bus.display_data = disp;
endmodule
